spi_master_tx: RTL and testbench

SPI mode-0 (CPOL=0, CPHA=0) master that drives the `sclk`/`mosi`/`nss` lines and samples `miso`. It is the initiator side of the serial command/data link into `archlearn`'s SPI slave, and is used on-chip and as a synthesizable bench driver in place of hand-toggled pins. It serializes one DATA_WIDTH word per frame, MSB first, and captures the simultaneous `miso` word. The host interface is a valid/ready handshake.

---
 rtl/spi_master_tx_pkg.sv | 27 ++
 rtl/spi_master_tx_clk_gen.sv | 39 +++
 rtl/spi_master_tx.sv | 160 ++++++++++++++++
 tb/tb_spi_master_tx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_tx_pkg.sv
// spi_pkg: shared types and constants for the SPI mode-0 master.
//   - spi_state_t : FSM state encoding (IDLE, SETUP, TRANSFER, HOLD, GAP)
//   - SPI_CPOL/SPI_CPHA : fixed mode constants (mode 0)
//   - DEF_DATA_WIDTH / DEF_CLK_DIV : default frame width and sclk divider
//   - cnt_width() : width of a counter holding 0..n-1 (never less than 1)
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_TRANSFER = 3'd2,
    ST_HOLD     = 3'd3,
    ST_GAP      = 3'd4
  } spi_state_t;

  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CLK_DIV    = 3;

  // $clog2(1) is 0, which would give a zero-width counter for CLK_DIV=1.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_master_tx_clk_gen.sv
// spi_clk_gen: half-period timer for the SPI master.
// Counts CLK_DIV clk cycles per phase and raises phase_end for one cycle
// on the last cycle of each phase.
// Ports:
//   clk, reset  : system clock, asynchronous active-high reset
//   start       : restart the count from 0 (a new word was accepted)
//   en          : count enable (high whenever the FSM is not idle)
//   phase_end   : one-cycle tick, last cycle of the current phase
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic en,
  output logic phase_end
);

  localparam int CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  // A restart cycle is the handshake edge itself; the new phase begins after it.
  assign phase_end = en && !start && (count == LAST);

endmodule

// File: rtl/spi_master_tx.sv
// spi_master_tx: SPI mode-0 (CPOL=0, CPHA=0) master, MSB first.
// Serializes one DATA_WIDTH word per frame on mosi and captures the
// simultaneous miso word. Optional macro SPI_MASTER_BURST_EN lets a new
// word be accepted during HOLD so consecutive words share one nss window.
//
// Host handshake: a word transfers on a rising clk edge where tx_valid and
// tx_ready are both 1. tx_data is sampled only on that edge. tx_valid
// while tx_ready is 0 is ignored; the host keeps it asserted until accepted.
//
// Ports:
//   clk, reset        : system clock, asynchronous active-high reset
//   tx_data/valid/ready : host word and handshake
//   rx_data, rx_valid : last captured miso word, one-cycle "new" pulse
//   busy              : frame in progress or inter-frame gap
//   sclk, mosi, miso, nss : SPI pins (sclk idles low, nss active low)
//   dbg_state         : current FSM state, for observation
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  nss,
  output spi_state_t            dbg_state
);

  localparam int BW = cnt_width(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  spi_state_t            state;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [BW-1:0]         bit_cnt;
  logic                  handshake;
  logic                  phase_end;

  // tx_ready is only ever 1 in states that may accept a word.
  assign handshake = tx_valid && tx_ready;
  assign rx_next   = {rx_shift[DATA_WIDTH-2:0], miso};
  assign dbg_state = state;

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .start    (handshake),
    .en       (state != ST_IDLE),
    .phase_end(phase_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      tx_ready <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      nss      <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            state    <= ST_SETUP;
            tx_shift <= tx_data;
            mosi     <= tx_data[DATA_WIDTH-1];
            bit_cnt  <= '0;
            nss      <= 1'b0;
            sclk     <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        ST_SETUP: begin
          if (phase_end) begin
            state <= ST_TRANSFER;
            sclk  <= 1'b1;
          end
        end

        // sclk itself tells which half we are in: a phase ending while sclk
        // is high is the falling edge, where miso is captured and mosi moves.
        ST_TRANSFER: begin
          if (phase_end) begin
            if (sclk) begin
              sclk     <= 1'b0;
              rx_shift <= rx_next;
              if (bit_cnt == LAST_BIT) begin
                state    <= ST_HOLD;
                bit_cnt  <= '0;
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                mosi     <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
                tx_ready <= 1'b1;
`endif
              end else begin
                bit_cnt  <= bit_cnt + 1'b1;
                mosi     <= tx_shift[DATA_WIDTH-2];
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
              end
            end else begin
              sclk <= 1'b1;
            end
          end
        end

        ST_HOLD: begin
`ifdef SPI_MASTER_BURST_EN
          // Next word rides the same nss window: straight back to SETUP.
          if (handshake) begin
            state    <= ST_SETUP;
            tx_shift <= tx_data;
            mosi     <= tx_data[DATA_WIDTH-1];
            bit_cnt  <= '0;
            tx_ready <= 1'b0;
          end else
`endif
          if (phase_end) begin
            state    <= ST_GAP;
            nss      <= 1'b1;
            tx_ready <= 1'b0;
          end
        end

        ST_GAP: begin
          if (phase_end) begin
            state    <= ST_IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: a default instance (CLK_DIV=3) and a CLK_DIV=1
// instance share one slave model on miso. A negedge monitor watches the
// selected instance: it collects mosi at sclk rises, times nss windows and
// rx_valid, and pops expected words from scoreboard queues.
module tb_spi_master_tx;
  import spi_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  logic [W-1:0] tx_data0, tx_data1, rx_data0, rx_data1;
  logic tx_valid0, tx_valid1, tx_ready0, tx_ready1;
  logic rx_valid0, rx_valid1, busy0, busy1;
  logic sclk0, sclk1, mosi0, mosi1, nss0, nss1;
  logic miso;
  spi_state_t st0, st1;

  spi_master_tx #(.DATA_WIDTH(W), .CLK_DIV(3)) dut (
    .clk(clk), .reset(rst), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .busy(busy0), .sclk(sclk0), .mosi(mosi0), .miso(miso), .nss(nss0),
    .dbg_state(st0)
  );

  spi_master_tx #(.DATA_WIDTH(W), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(rst), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .busy(busy1), .sclk(sclk1), .mosi(mosi1), .miso(miso), .nss(nss1),
    .dbg_state(st1)
  );

  // Monitor view of the selected instance.
  logic sel;
  logic m_sclk, m_mosi, m_nss, m_tx_ready, m_rx_valid;
  logic [W-1:0] m_rx_data;
  int m_div;
  assign m_sclk     = sel ? sclk1 : sclk0;
  assign m_mosi     = sel ? mosi1 : mosi0;
  assign m_nss      = sel ? nss1 : nss0;
  assign m_tx_ready = sel ? tx_ready1 : tx_ready0;
  assign m_rx_valid = sel ? rx_valid1 : rx_valid0;
  assign m_rx_data  = sel ? rx_data1 : rx_data0;
  assign m_div      = sel ? 1 : 3;

  // Scoreboard.
  logic [W-1:0] exp_q[$];     // expected mosi words
  logic [W-1:0] exp_rx_q[$];  // expected rx_data words
  logic [W-1:0] slave_q[$];   // words the slave model will return

  int n_checks = 0;
  int n_pass = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endfunction

  function automatic void chk_ge(input string name, input int act, input int lim);
    n_checks++;
    if (act >= lim) n_pass++;
    else $display("FAIL %s: got %0d expected at least %0d", name, act, lim);
  endfunction

  function automatic void fail(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired", name);
  endfunction

  // Monitor and slave model state.
  logic prev_nss = 1'b1, prev_sclk = 1'b0, need_load = 1'b1, gap_valid = 1'b0;
  logic [W-1:0] slave_word = '0, mword = '0;
  int sbits = 0, mbits = 0, frame_cyc = 0, low_cnt = 0, hi_cnt = 0;
  int win_words = 0, rx_in_win = 0, rises_in_win = 0, rx_pulses = 0;
  int mosi_bad = 0, ready_bad = 0, exp_low = 0, exp_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_nss = 1'b1; prev_sclk = 1'b0; need_load = 1'b1; gap_valid = 1'b0;
      miso = 1'b0; sbits = 0; mbits = 0; win_words = 0; rises_in_win = 0;
    end else begin
      if (prev_nss && !m_nss) begin
        if (gap_valid) chk_ge("gap_len", hi_cnt, m_div);
        frame_cyc = 0; low_cnt = 0; win_words = 0; rx_in_win = 0;
        rises_in_win = 0; mbits = 0;
      end else begin
        frame_cyc++;
      end
      if (!prev_nss && m_nss) begin
        exp_low = win_words * m_div * (2 * W + 1) - (win_words - 1) * (m_div - 1);
        chk("nss_low_len", low_cnt, exp_low);
        hi_cnt = 0;
        gap_valid = 1'b1;
      end
      if (!m_nss) begin
        low_cnt++;
`ifndef SPI_MASTER_BURST_EN
        if (m_tx_ready) ready_bad++;
`endif
        if (need_load && slave_q.size() > 0) begin
          slave_word = slave_q.pop_front();
          miso = slave_word[W-1];
          need_load = 1'b0;
          sbits = 0;
        end
        if (!prev_sclk && m_sclk) begin
          if (rises_in_win == 0) chk("first_rise_cycle", frame_cyc, m_div);
          rises_in_win++;
          mword = {mword[W-2:0], m_mosi};
          mbits++;
          if (mbits == W) begin
            if (exp_q.size() > 0) chk("mosi_word", int'(mword), int'(exp_q.pop_front()));
            else fail("mosi_unexpected");
            mbits = 0;
            win_words++;
          end
        end
        if (prev_sclk && !m_sclk) begin
          sbits++;
          if (sbits == W) need_load = 1'b1;
          else begin
            slave_word = {slave_word[W-2:0], 1'b0};
            miso = slave_word[W-1];
          end
        end
      end else begin
        hi_cnt++;
        if (m_mosi) mosi_bad++;
      end
      if (m_rx_valid) begin
        exp_cyc = m_div * 2 * W + rx_in_win * (m_div * 2 * W + 1);
        chk("rx_valid_cycle", frame_cyc, exp_cyc);
        rx_in_win++;
        rx_pulses++;
        if (exp_rx_q.size() > 0) chk("rx_data", int'(m_rx_data), int'(exp_rx_q.pop_front()));
        else fail("rx_unexpected");
      end
      prev_nss = m_nss;
      prev_sclk = m_sclk;
    end
  end

  // Driver: offer a word on the selected instance and hold it until accepted.
  task automatic send(input logic [W-1:0] d, input logic [W-1:0] s);
    int b;
    slave_q.push_back(s);
    exp_q.push_back(d);
    exp_rx_q.push_back(s);
    @(negedge clk);
    if (sel) begin tx_data1 = d; tx_valid1 = 1'b1; end
    else begin tx_data0 = d; tx_valid0 = 1'b1; end
    b = 0;
    while (!m_tx_ready && b < 400) begin @(negedge clk); b++; end
    if (b >= 400) fail("send_timeout");
    @(posedge clk);
    #1;
    tx_valid0 = 1'b0;
    tx_valid1 = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((exp_rx_q.size() != 0 || exp_q.size() != 0 || !m_nss || !m_tx_ready) && b < 1000) begin
      @(negedge clk);
      b++;
    end
    if (b >= 1000) fail("drain_timeout");
    repeat (5) @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] tx;
    logic [W-1:0] slave;
    logic [W-1:0] exp_rx;
  } vec_t;
  vec_t vecs[5];

  int pulses0, r, b;
  logic p;
  logic [W-1:0] rnd;

  initial begin
    vecs[0] = '{8'h30, 8'hA5, 8'hA5};
    vecs[1] = '{8'hFF, 8'h0F, 8'h0F};
    vecs[2] = '{8'h00, 8'hF0, 8'hF0};
    vecs[3] = '{8'hC3, 8'h3C, 8'h3C};
    vecs[4] = '{8'h6E, 8'h91, 8'h91};

    rst = 1'b1; sel = 1'b0; miso = 1'b0;
    tx_valid0 = 1'b0; tx_valid1 = 1'b0; tx_data0 = '0; tx_data1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_nss", nss0, 1);
    chk("rst_sclk", sclk0, 0);
    chk("rst_mosi", mosi0, 0);
    chk("rst_tx_ready", tx_ready0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_rx_valid", rx_valid0, 0);
    chk("rst_rx_data", int'(rx_data0), 0);
    chk("rst_state", int'(st0), int'(ST_IDLE));
    chk("rst_nss_div1", nss1, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back table words; each next word is offered as soon as the
    // previous one is accepted, so it lands the cycle tx_ready returns.
    pulses0 = rx_pulses;
    for (int i = 0; i < 5; i++) send(vecs[i].tx, vecs[i].exp_rx);
    drain();
    chk("table_rx_pulses", rx_pulses - pulses0, 5);

    // tx_valid held with tx_data wandering; the value at the accepting edge wins.
    pulses0 = rx_pulses;
    send(8'h11, 8'h22);
    tx_valid0 = 1'b1;
    b = 0;
    while (!tx_ready0 && b < 400) begin
      rnd = W'($urandom_range(0, 255));
      tx_data0 = rnd;
      @(negedge clk);
      b++;
    end
    if (b >= 400) fail("held_timeout");
    exp_q.push_back(tx_data0);
    slave_q.push_back(8'h77);
    exp_rx_q.push_back(8'h77);
    @(posedge clk);
    #1;
    tx_valid0 = 1'b0;
    drain();
    chk("held_rx_pulses", rx_pulses - pulses0, 2);

    // Reset at the 4th sclk rise.
    pulses0 = rx_pulses;
    chk_ge("pre_reset_rx_data_nonzero", int'(rx_data0), 1);
    send(8'h99, 8'h66);
    r = 0; b = 0; p = sclk0;
    while (r < 4 && b < 400) begin
      @(posedge clk);
      #1;
      if (sclk0 && !p) r++;
      p = sclk0;
      b++;
    end
    if (b >= 400) fail("rise4_timeout");
    rst = 1'b1;
    #1;
    chk("midrst_nss", nss0, 1);
    chk("midrst_sclk", sclk0, 0);
    chk("midrst_rx_valid", rx_valid0, 0);
    repeat (3) @(negedge clk);
    chk("midrst_rx_data", int'(rx_data0), 0);
    exp_q.delete(); exp_rx_q.delete(); slave_q.delete();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_no_pulse", rx_pulses - pulses0, 0);
    send(8'h5A, 8'hC3);
    drain();
    chk("post_rst_rx_data", int'(rx_data0), 8'hC3);

    // CLK_DIV=1 instance.
    sel = 1'b1;
    repeat (2) @(negedge clk);
    pulses0 = rx_pulses;
    send(8'h81, 8'h7E);
    drain();
    chk("div1_rx_pulses", rx_pulses - pulses0, 1);
    sel = 1'b0;
    repeat (2) @(negedge clk);

`ifdef SPI_MASTER_BURST_EN
    pulses0 = rx_pulses;
    send(8'h12, 8'hAB);
    send(8'h34, 8'hCD);
    drain();
    chk("burst_rx_pulses", rx_pulses - pulses0, 2);
`endif

    chk("mosi_zero_when_nss_high", mosi_bad, 0);
`ifndef SPI_MASTER_BURST_EN
    chk("tx_ready_low_in_frame", ready_bad, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
